// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter
//   Iterative binary-to-BCD converter (shift-and-add-3 / double-dabble) with a
//   start/done handshake. Inputs that exceed 10^DIGITS-1 saturate the output
//   to all-nines and raise overflow.
//
// Ports:
//   clk       in   clock, rising-edge
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, sampled only while idle
//   bin       in   [BIN_W-1:0] binary value, captured on the accepting edge
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when bcd/overflow are updated
//   bcd       out  [4*DIGITS-1:0] packed BCD, units digit in [3:0]
//   overflow  out  last accepted bin exceeded 10^DIGITS-1
module bin_to_bcd_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // Scratch carries one extra nibble so the top digit of an out-of-range
  // value has somewhere to go; its content is never presented on bcd.
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(BIN_W + 1);

  function automatic logic [63:0] f_pow10_m1(input int unsigned n);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = f_pow10_m1(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [BIN_W-1:0]    r_bin;
  logic [SW-1:0]       r_scratch;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_overflow;

  logic [SW-1:0]       w_adj;
  logic                w_over_max;

  // Per-nibble add-3 correction; 4-bit add, no carry between digits.
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  assign w_over_max = 64'(bin) > MAX_VAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin     <= bin;
            r_scratch <= '0;
            r_ovf     <= w_over_max;
            r_cnt     <= CW'(BIN_W);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_bin} <= {w_adj[SW-2:0], r_bin, 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd      <= r_ovf ? {DIGITS{4'h9}} : r_scratch[4*DIGITS-1:0];
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
module tb_bin_to_bcd_converter;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  bin_to_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference: decimal digits by plain division, saturating above 9999.
  function automatic exp_t ref_conv(input int v, input int acc);
    exp_t e;
    e.acc = acc;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request keeps the block busy for
  // LAT edges, then the result appears together with done.
  int cyc      = 0;
  int left     = 0;
  bit m_done   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   = 0;
      m_done = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      m_done = 1'b0;
      if (left == 0) begin
        if (start === 1'b1) begin
          sb.push_back(ref_conv(int'(bin), cyc));
          left = LAT;
        end
      end else begin
        left--;
        if (left == 0) m_done = 1'b1;
      end
    end
  end

  logic [15:0] exp_bcd = '0;
  logic        exp_ovf = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_bcd = '0;
      exp_ovf = 1'b0;
    end
    chk("busy", 32'(busy), 32'(left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("busy_done_excl", 32'(busy & done), 32'd0);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'(LAT));
        exp_bcd = e.bcd;
        exp_ovf = e.ovf;
      end
    end
    chk("bcd", 32'(bcd), 32'(exp_bcd));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  end

  task automatic conv(input int v);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
    repeat (18) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;

    // Reset held with start toggling.
    repeat (6) begin
      @(negedge clk);
      start = ~start;
      bin   = 14'($urandom_range(0, 16383));
    end
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic and saturating conversions.
    conv(0);
    conv(1234);
    conv(9999);
    conv(10000);
    conv(16383);
    conv(42);

    // Start pulses during SHIFT (edge 3) and DONE (edge 15) are ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 14'd1111;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    bin   = 14'd1111;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd256;
    repeat (64) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic; bin wanders after acceptance, biased near the limit.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      bin   = (($urandom % 4) == 0) ? 14'($urandom_range(9990, 10010))
                                    : 14'($urandom_range(0, 16383));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts, then a fresh conversion completes.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    conv(4321);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
